// File: rtl/torus_sink_pkg.sv
// +----------------------------------------------------------------------------+
// | torus_sink_pkg                                                             |
// | Shared NoC test definitions: field widths, payload offsets, error codes.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package torus_sink_pkg;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_DST   = 2'd1;
    localparam logic [1:0] ERR_DUP   = 2'd2;
    localparam logic [1:0] ERR_RANGE = 2'd3;

    // Field widths never collapse to zero, so 1-wide dimensions still decode.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int seq_lsb();
        return 0;
    endfunction

    function automatic int src_x_lsb(input int sw);
        return sw;
    endfunction

    function automatic int src_y_lsb(input int sw, input int xw);
        return sw + xw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sink_scoreboard.sv
// +----------------------------------------------------------------------------+
// | sink_scoreboard                                                            |
// | Delivery bitmap with single-cycle test-and-set port and synchronous clear. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sink_scoreboard #(
    parameter int DEPTH = 320,
    parameter int IW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] i_idx,
    input  logic          i_set,
    output logic          o_hit
);

    logic [DEPTH-1:0] r_bits;
    logic             w_in_range;

    assign w_in_range = (int'(i_idx) < DEPTH);
    assign o_hit      = w_in_range ? r_bits[i_idx] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bits <= '0;
        end else if (i_set && w_in_range) begin
            r_bits[i_idx] <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/torus_sink.sv
// +----------------------------------------------------------------------------+
// | torus_sink                                                                 |
// | Per-node packet receiver: destination/range/duplicate checks and counting. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module torus_sink
    import torus_sink_pkg::*;
#(
    parameter int D_W      = 16,
    parameter int X_DIM    = 4,
    parameter int Y_DIM    = 4,
    parameter int MEM_D    = 20,
    parameter int MY_X     = 0,
    parameter int MY_Y     = 0,
    parameter int EXP_PKTS = 20
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     i_valid,
    input  logic [clog2_min1(Y_DIM)+clog2_min1(X_DIM)+D_W-1:0]       i_data,
    output logic [clog2_min1(EXP_PKTS+1)-1:0]                        o_count,
    output logic                                                     o_done,
    output logic                                                     o_err,
    output logic [1:0]                                               o_err_code,
    output logic [clog2_min1(Y_DIM)+clog2_min1(X_DIM)+D_W-1:0]       o_err_data
);

    localparam int c_xw    = clog2_min1(X_DIM);
    localparam int c_yw    = clog2_min1(Y_DIM);
    localparam int c_sw    = clog2_min1(MEM_D);
    localparam int c_cw    = clog2_min1(EXP_PKTS + 1);
    localparam int c_iw    = c_yw + c_xw + D_W;
    localparam int c_depth = X_DIM * Y_DIM * MEM_D;
    localparam int c_bw    = clog2_min1(c_depth);

    logic [c_yw-1:0] w_dst_y;
    logic [c_xw-1:0] w_dst_x;
    logic [c_yw-1:0] w_src_y;
    logic [c_xw-1:0] w_src_x;
    logic [c_sw-1:0] w_seq;
    logic [c_bw-1:0] w_idx;
    logic            w_hit;
    logic [1:0]      w_code;
    logic            w_accept;

    logic [c_cw-1:0] r_count;
    logic            r_done;
    logic            r_err;
    logic [1:0]      r_err_code;
    logic [c_iw-1:0] r_err_data;

    assign w_dst_y = i_data[c_iw-1 -: c_yw];
    assign w_dst_x = i_data[D_W +: c_xw];
    assign w_src_y = i_data[src_y_lsb(c_sw, c_xw) +: c_yw];
    assign w_src_x = i_data[src_x_lsb(c_sw) +: c_xw];
    assign w_seq   = i_data[seq_lsb() +: c_sw];

    assign w_idx = c_bw'((int'(w_src_y) * X_DIM + int'(w_src_x)) * MEM_D + int'(w_seq));

    always_comb begin
        w_code = ERR_NONE;
        if ((w_dst_x != c_xw'(MY_X)) || (w_dst_y != c_yw'(MY_Y))) begin
            w_code = ERR_DST;
        end else if ((int'(w_seq) >= MEM_D) || (int'(w_src_x) >= X_DIM) ||
                     (int'(w_src_y) >= Y_DIM)) begin
            w_code = ERR_RANGE;
        end else if (w_hit) begin
            w_code = ERR_DUP;
        end
    end

    assign w_accept = i_valid && (w_code == ERR_NONE);

    sink_scoreboard #(
        .DEPTH (c_depth),
        .IW    (c_bw)
    ) u_scoreboard (
        .clk   (clk),
        .rst   (rst),
        .i_idx (w_idx),
        .i_set (w_accept),
        .o_hit (w_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_err_data <= '0;
        end else if (i_valid) begin
            if (w_accept) begin
                if (r_count != c_cw'(EXP_PKTS)) begin
                    r_count <= r_count + c_cw'(1);
                end
                if (r_count == c_cw'(EXP_PKTS - 1)) begin
                    r_done <= 1'b1;
                end
            end else begin
                r_err <= 1'b1;
                // Only the first error is kept for post-mortem.
                if (!r_err) begin
                    r_err_code <= w_code;
                    r_err_data <= i_data;
                end
            end
        end
    end

    assign o_count    = r_count;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;
    assign o_err_data = r_err_data;

endmodule

`default_nettype wire

// File: tb/tb_torus_sink.sv
// +----------------------------------------------------------------------------+
// | tb_torus_sink                                                              |
// | Directed vector bench for torus_sink at node (1,2) of a 4x4 torus.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_torus_sink;

    localparam int c_nvec = 17;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [19:0] data;
        logic [4:0]  exp_count;
        logic        exp_done;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [19:0] exp_data;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [19:0] data;
    logic [4:0]  count;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [19:0] err_data;

    int checks;
    int errors;

    vec_t vecs [c_nvec];

    torus_sink #(
        .D_W      (16),
        .X_DIM    (4),
        .Y_DIM    (4),
        .MEM_D    (20),
        .MY_X     (1),
        .MY_Y     (2),
        .EXP_PKTS (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (valid),
        .i_data     (data),
        .o_count    (count),
        .o_done     (done),
        .o_err      (err),
        .o_err_code (err_code),
        .o_err_data (err_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] pkt(input int dx, input int dy, input int sx,
                                        input int sy, input int seq, input int hi);
        return {2'(dy), 2'(dx), 7'(hi), 2'(sy), 2'(sx), 5'(seq)};
    endfunction

    function automatic vec_t mkv(input logic r, input logic v, input logic [19:0] d,
                                 input int c, input logic dn, input logic e,
                                 input int code, input logic [19:0] ed);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d; t.exp_count = 5'(c);
        t.exp_done = dn; t.exp_err = e; t.exp_code = 2'(code); t.exp_data = ed;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input logic dn, input logic e,
                             input int code, input logic [19:0] ed);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".err"}, 32'(err), 32'(e));
        chk({tag, ".code"}, 32'(err_code), 32'(code));
        chk({tag, ".data"}, 32'(err_data), 32'(ed));
    endtask

    task automatic step(input logic r, input logic v, input logic [19:0] d);
        rst = r; valid = v; data = d;
        @(posedge clk);
        #1;
        rst = 1'b0; valid = 1'b0;
    endtask

    initial begin
        logic [19:0] p_dup, p_wd, p_rng, p_hi1, p_hi2;
        checks = 0;
        errors = 0;
        rst = 1'b1; valid = 1'b0; data = '0;

        p_dup = pkt(1, 2, 3, 1, 5, 0);
        p_wd  = pkt(2, 2, 0, 0, 0, 0);
        p_rng = pkt(1, 2, 1, 1, 25, 0);
        p_hi1 = pkt(1, 2, 2, 3, 19, 7'h55);
        p_hi2 = pkt(1, 2, 2, 3, 19, 7'h2a);

        vecs[0]  = mkv(1, 0, '0,                    0, 0, 0, 0, '0);
        vecs[1]  = mkv(0, 1, p_dup,                 1, 0, 0, 0, '0);
        vecs[2]  = mkv(0, 1, p_dup,                 1, 0, 1, 2, p_dup);
        vecs[3]  = mkv(0, 0, p_wd,                  1, 0, 1, 2, p_dup);
        vecs[4]  = mkv(1, 1, pkt(1, 2, 0, 0, 1, 0), 0, 0, 0, 0, '0);
        vecs[5]  = mkv(0, 1, p_wd,                  0, 0, 1, 1, p_wd);
        vecs[6]  = mkv(0, 1, pkt(1, 2, 0, 0, 0, 0), 1, 0, 1, 1, p_wd);
        vecs[7]  = mkv(0, 1, pkt(1, 2, 0, 0, 0, 0), 1, 0, 1, 1, p_wd);
        vecs[8]  = mkv(1, 0, '0,                    0, 0, 0, 0, '0);
        vecs[9]  = mkv(0, 1, p_rng,                 0, 0, 1, 3, p_rng);
        vecs[10] = mkv(0, 1, pkt(1, 2, 1, 1, 5, 0), 1, 0, 1, 3, p_rng);
        vecs[11] = mkv(0, 0, p_wd,                  1, 0, 1, 3, p_rng);
        vecs[12] = mkv(1, 0, '0,                    0, 0, 0, 0, '0);
        vecs[13] = mkv(0, 1, p_hi1,                 1, 0, 0, 0, '0);
        vecs[14] = mkv(0, 1, p_hi2,                 1, 0, 1, 2, p_hi2);
        vecs[15] = mkv(1, 0, '0,                    0, 0, 0, 0, '0);
        vecs[16] = mkv(0, 0, p_wd,                  0, 0, 0, 0, '0);

        @(posedge clk);
        #1;
        for (int i = 0; i < c_nvec; i++) begin
            step(vecs[i].rst, vecs[i].valid, vecs[i].data);
            check_all($sformatf("vec%0d", i), int'(vecs[i].exp_count), vecs[i].exp_done,
                      vecs[i].exp_err, int'(vecs[i].exp_code), vecs[i].exp_data);
        end

        // Full delivery: 20 distinct packets, done only on the last accept.
        step(1, 0, '0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, pkt(1, 2, 0, 0, i, 0));
            chk($sformatf("fill%0d.count", i), 32'(count), 32'(i + 1));
            chk($sformatf("fill%0d.done", i), 32'(done), 32'(i == 19));
        end
        chk("fill.err", 32'(err), 32'd0);
        step(0, 1, pkt(1, 2, 0, 0, 0, 0));
        check_all("after_done", 20, 1, 1, 2, pkt(1, 2, 0, 0, 0, 0));

        // Reset mid-run with a valid packet on the reset cycle, then replay.
        step(1, 0, '0);
        for (int i = 0; i < 7; i++) step(0, 1, pkt(1, 2, 2, 1, i, 0));
        chk("pre_rst.count", 32'(count), 32'd7);
        step(1, 1, pkt(1, 2, 2, 1, 8, 0));
        check_all("mid_rst", 0, 0, 0, 0, '0);
        for (int i = 0; i < 7; i++) step(0, 1, pkt(1, 2, 2, 1, i, 0));
        check_all("replay", 7, 0, 0, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/torus_sink.md
# torus_sink

Per-node packet receiver and checker for the torus NoC test environment. It sits on the exit (client-out) port of every router and consumes the packets that the per-node traffic generators inject under the configured rate/token limits. It checks that each packet reached the correct destination and that no packet arrives twice or carries an out-of-range sequence number. It counts deliveries and raises `o_done` when the expected number of packets has arrived, so the bench can end on completion instead of on a fixed cycle count.

## Interface
- `D_W`, 16, payload width; must be ≥ YW+XW+SW.
- `X_DIM`, 4, torus X dimension.
- `Y_DIM`, 4, torus Y dimension.
- `MEM_D`, 20, packets sent per source (generator memory depth).
- `MY_X`, 0, this node's X coordinate.
- `MY_Y`, 0, this node's Y coordinate.
- `EXP_PKTS`, 20, total packets addressed to this node.
- Derived widths: XW = max(1, clog2(X_DIM)); YW = max(1, clog2(Y_DIM)); SW = max(1, clog2(MEM_D)); CW = clog2(EXP_PKTS+1).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: exit-port packet valid. There is no backpressure, so every valid cycle must be consumed.
- `i_data` in YW+XW+D_W: packet `{dst_y, dst_x, payload}`. Payload low bits are `{src_y, src_x, seq}`, with `seq` in [SW-1:0]; upper payload bits are ignored.
- `o_count` out CW: number of accepted (non-error) packets.
- `o_done` out 1: `o_count == EXP_PKTS`; sticky until reset.
- `o_err` out 1: sticky; set on any error.
- `o_err_code` out 2: code of the first error. 0 = none, 1 = wrong destination, 2 = duplicate, 3 = seq ≥ MEM_D or src out of range.
- `o_err_data` out YW+XW+D_W: `i_data` of the first erroring packet.

## Operation
- Scoreboard: bitmap of X_DIM·Y_DIM·MEM_D flops. Index = (src_y·X_DIM + src_x)·MEM_D + seq.
- On each cycle with `i_valid`=1, checks run in this priority order:
  1. If dst ≠ (MY_X, MY_Y): wrong-destination error.
  2. Else if seq ≥ MEM_D, src_x ≥ X_DIM or src_y ≥ Y_DIM: range error.
  3. Else if the scoreboard bit is already set: duplicate error.
  4. Else: set the bit and increment `o_count`.
- On an error: scoreboard and count are unchanged. `o_err` is set. `o_err_code` and `o_err_data` load only if `o_err` was 0 (first error wins).
- Arrival order is not checked, because deflection routing reorders packets.
- `o_count` saturates at EXP_PKTS. A further valid non-duplicate packet after `o_done` is impossible by construction; if one arrives it is a range or duplicate error.
- `i_data` is ignored when `i_valid`=0.

## Timing
- Latency is 1 cycle. A packet sampled at edge N is reflected in `o_count`, `o_done` and `o_err*` after edge N.
- The check and the bitmap set happen in the same cycle. The same packet arriving on two consecutive cycles is therefore flagged as a duplicate on the second one; no bypass is needed.
- Reset values: bitmap all 0, `o_count`=0, `o_done`=0, `o_err`=0, `o_err_code`=0, `o_err_data`=0.
- `rst` takes priority over `i_valid` in the same cycle. A packet presented during reset is dropped.
- Asserting `rst` mid-run clears all state; packets that arrive afterwards are counted as new.
- `o_done` is registered: it rises on the edge that accepts packet number EXP_PKTS.

## Structure
- Shared NoC test package holds: the XW/YW/SW width functions (clog2 with a floor of 1), the payload field offsets, and the error-code constants (`ERR_NONE`, `ERR_DST`, `ERR_DUP`, `ERR_RANGE`).
- One sub-module, `sink_scoreboard`: the bitmap with a single-cycle test-and-set port (index, set enable, hit output) and synchronous clear.
- The top level holds the decode, checks, counter and first-error capture.

## Test plan
- Defaults, MY=(1,2): send 20 distinct packets (src (0,0), seq 0..19) with dst (1,2) → `o_count` steps 1..20; `o_done`=1 after the 20th accept; `o_err`=0.
- Duplicate: send src (3,1) seq 5 twice back-to-back → `o_count`=1, `o_err`=1, `o_err_code`=2, `o_err_data` = the second packet.
- Wrong destination: packet with dst (2,2) to node (1,2) → count 0, code 1. A following duplicate-class error leaves code at 1 (first error wins).
- Range: seq=25 with MEM_D=20 → code 3, scoreboard untouched; a later legal packet with seq 5 is still accepted (count 1).
- Reset mid-run: accept 7 packets, hold `rst` for 1 cycle while `i_valid`=1 → all outputs 0. Replaying the same 7 packets gives count 7 with no duplicate errors.
- Full system: 4×4 torus, every node's generator sends its MEM_D packets → every sink reaches `o_done` with `o_err`=0, and the sum of all `o_count` = 16·20 = 320.
